// File: rtl/branch_unit_bp.sv
`default_nettype none
// ============================================================================
// Module   : branch_unit_bp
// Purpose  : One-cycle branch/JAL/JALR resolution against the fetch prediction,
//            with a 2-bit saturating-counter BHT trained on conditional branches
//            and a combinational fetch-side lookup port.
//            Optional: define BRANCH_UNIT_BP_GSHARE_EN for gshare indexing.
// Revision : 1.0 - initial release
// ============================================================================
module branch_unit_bp #(
  parameter int DATA_WIDTH  = 32,
  parameter int ROB_WIDTH   = 4,
  parameter int BHT_ENTRIES = 64,
  parameter int BHT_IDX_W   = $clog2(BHT_ENTRIES)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [DATA_WIDTH-1:0] i_op1,
  input  logic [DATA_WIDTH-1:0] i_op2,
  input  logic [DATA_WIDTH-1:0] i_pc,
  input  logic [DATA_WIDTH-1:0] i_imm,
  input  logic [3:0]            i_alu_op,
  input  logic [ROB_WIDTH-1:0]  i_rob_tag,
  input  logic                  i_pred_taken,
  input  logic [DATA_WIDTH-1:0] i_pred_target,
  input  logic                  i_flush,
  output logic                  o_valid,
  input  logic                  i_out_ready,
  output logic [ROB_WIDTH-1:0]  o_rob_tag,
  output logic                  o_taken,
  output logic [DATA_WIDTH-1:0] o_target_addr,
  output logic [DATA_WIDTH-1:0] o_redirect_pc,
  output logic                  o_mispredict,
  output logic [DATA_WIDTH-1:0] o_result,
  input  logic [DATA_WIDTH-1:0] i_fetch_pc,
  output logic                  o_fetch_pred_taken
);

  localparam logic [3:0] OP_JAL  = 4'b1100;
  localparam logic [3:0] OP_JALR = 4'b1101;

  logic                  accept;
  logic                  is_jal;
  logic                  is_jalr;
  logic                  is_cond;
  logic                  cond_taken;
  logic                  taken;
  logic                  mispredict;
  logic [DATA_WIDTH-1:0] pc_plus4;
  logic [DATA_WIDTH-1:0] jalr_sum;
  logic [DATA_WIDTH-1:0] target;
  logic [DATA_WIDTH-1:0] redirect;
  logic [BHT_IDX_W-1:0]  upd_idx;
  logic [BHT_IDX_W-1:0]  fetch_idx;
  logic [1:0]            ctr_cur;
  logic [1:0]            ctr_next;
  logic [1:0]            bht [BHT_ENTRIES];
  logic                  fetch_pc_unused;

  assign o_ready = !o_valid || i_out_ready;
  assign accept  = i_valid && o_ready && !i_flush;

  assign is_jal  = (i_alu_op == OP_JAL);
  assign is_jalr = (i_alu_op == OP_JALR);
  assign is_cond = !is_jal && !is_jalr;

  always_comb begin
    cond_taken = 1'b0;
    case (i_alu_op[2:0])
      3'b000:  cond_taken = (i_op1 == i_op2);
      3'b001:  cond_taken = (i_op1 != i_op2);
      3'b100:  cond_taken = ($signed(i_op1) <  $signed(i_op2));
      3'b101:  cond_taken = ($signed(i_op1) >= $signed(i_op2));
      3'b110:  cond_taken = (i_op1 <  i_op2);
      3'b111:  cond_taken = (i_op1 >= i_op2);
      default: cond_taken = 1'b0;
    endcase
  end

  assign taken    = is_jal || is_jalr || cond_taken;
  assign pc_plus4 = i_pc + DATA_WIDTH'(4);
  assign jalr_sum = i_op1 + i_imm;
  assign target   = is_jalr ? {jalr_sum[DATA_WIDTH-1:2], 2'b00} : (i_pc + i_imm);
  assign redirect = taken ? target : pc_plus4;

  // A taken/taken pair is still wrong if fetch steered to a different address.
  assign mispredict = (taken != i_pred_taken) ||
                      (taken && i_pred_taken && (target != i_pred_target));

`ifdef BRANCH_UNIT_BP_GSHARE_EN
  logic [BHT_IDX_W-1:0] ghist;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ghist <= '0;
    end else if (accept && is_cond) begin
      ghist <= BHT_IDX_W'({ghist, taken});
    end
  end

  assign upd_idx   = i_pc[BHT_IDX_W+1:2] ^ ghist;
  assign fetch_idx = i_fetch_pc[BHT_IDX_W+1:2] ^ ghist;
`else
  assign upd_idx   = i_pc[BHT_IDX_W+1:2];
  assign fetch_idx = i_fetch_pc[BHT_IDX_W+1:2];
`endif

  assign fetch_pc_unused = ^i_fetch_pc;

  assign ctr_cur = bht[upd_idx];

  always_comb begin
    ctr_next = ctr_cur;
    if (taken && (ctr_cur != 2'b11)) begin
      ctr_next = ctr_cur + 2'b01;
    end else if (!taken && (ctr_cur != 2'b00)) begin
      ctr_next = ctr_cur - 2'b01;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BHT_ENTRIES; i++) begin
        bht[i] <= 2'b01;
      end
    end else if (accept && is_cond) begin
      bht[upd_idx] <= ctr_next;
    end
  end

  // Reads the stored counter, so a same-cycle update is not visible yet.
  assign o_fetch_pred_taken = bht[fetch_idx][1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_valid       <= 1'b0;
      o_rob_tag     <= '0;
      o_taken       <= 1'b0;
      o_target_addr <= '0;
      o_redirect_pc <= '0;
      o_mispredict  <= 1'b0;
      o_result      <= '0;
    end else if (i_flush) begin
      o_valid <= 1'b0;
    end else if (accept) begin
      o_valid       <= 1'b1;
      o_rob_tag     <= i_rob_tag;
      o_taken       <= taken;
      o_target_addr <= target;
      o_redirect_pc <= redirect;
      o_mispredict  <= mispredict;
      o_result      <= pc_plus4;
    end else if (i_out_ready) begin
      o_valid <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_branch_unit_bp.sv
`default_nettype none
// Testbench for branch_unit_bp: directed scenarios plus randomized traffic
// checked against a behavioural model of the resolution and BHT rules.
module tb_branch_unit_bp;

  localparam int DW      = 32;
  localparam int RW      = 4;
  localparam int ENTRIES = 64;

  localparam logic [3:0] BEQ  = 4'b0000;
  localparam logic [3:0] BNE  = 4'b0001;
  localparam logic [3:0] BLT  = 4'b0100;
  localparam logic [3:0] BLTU = 4'b0110;
  localparam logic [3:0] JAL  = 4'b1100;
  localparam logic [3:0] JALR = 4'b1101;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          valid, ready, flush, out_ready;
  logic [DW-1:0] op1, op2, pc, imm, pred_target, fetch_pc;
  logic [3:0]    alu_op;
  logic [RW-1:0] rob_tag;
  logic          pred_taken;
  logic          res_valid, taken, mispredict, fetch_pred;
  logic [RW-1:0] res_tag;
  logic [DW-1:0] target_addr, redirect_pc, result;

  int tests_run    = 0;
  int tests_failed = 0;

  // Reference model state
  logic          m_valid;
  logic [RW-1:0] m_tag;
  logic          m_taken, m_mis;
  logic [DW-1:0] m_target, m_redirect, m_result;
  int            m_bht [ENTRIES];
  int            m_hist;

  always #5 clk = ~clk;

  branch_unit_bp #(
    .DATA_WIDTH (DW),
    .ROB_WIDTH  (RW),
    .BHT_ENTRIES(ENTRIES)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .i_valid           (valid),
    .o_ready           (ready),
    .i_op1             (op1),
    .i_op2             (op2),
    .i_pc              (pc),
    .i_imm             (imm),
    .i_alu_op          (alu_op),
    .i_rob_tag         (rob_tag),
    .i_pred_taken      (pred_taken),
    .i_pred_target     (pred_target),
    .i_flush           (flush),
    .o_valid           (res_valid),
    .i_out_ready       (out_ready),
    .o_rob_tag         (res_tag),
    .o_taken           (taken),
    .o_target_addr     (target_addr),
    .o_redirect_pc     (redirect_pc),
    .o_mispredict      (mispredict),
    .o_result          (result),
    .i_fetch_pc        (fetch_pc),
    .o_fetch_pred_taken(fetch_pred)
  );

  function automatic int m_idx(logic [DW-1:0] addr);
    int base;
    base = int'((addr >> 2) % ENTRIES);
`ifdef BRANCH_UNIT_BP_GSHARE_EN
    return base ^ m_hist;
`else
    return base;
`endif
  endfunction

  function automatic logic m_pred(logic [DW-1:0] addr);
    return m_bht[m_idx(addr)] >= 2;
  endfunction

  task automatic resolve(input logic [3:0] op, input logic [DW-1:0] a, b, p, im, ptgt,
                         input logic ptk, output logic tk, output logic [DW-1:0] tgt,
                         output logic mis);
    int sa, sb;
    sa = a;
    sb = b;
    if (op == JAL || op == JALR) tk = 1'b1;
    else begin
      case (op[2:0])
        3'd0:    tk = (a == b);
        3'd1:    tk = (a != b);
        3'd4:    tk = (sa < sb);
        3'd5:    tk = (sa >= sb);
        3'd6:    tk = (a < b);
        3'd7:    tk = (a >= b);
        default: tk = 1'b0;
      endcase
    end
    if (op == JALR) tgt = ((a + im) >> 2) << 2;
    else            tgt = p + im;
    mis = (tk != ptk) || (tk && ptk && (tgt != ptgt));
  endtask

  task automatic model_reset();
    m_valid = 0; m_tag = '0; m_taken = 0; m_mis = 0;
    m_target = '0; m_redirect = '0; m_result = '0;
    for (int e = 0; e < ENTRIES; e++) m_bht[e] = 1;
    m_hist = 0;
  endtask

  task automatic model_step();
    logic rdy, acc, tk, mis;
    logic [DW-1:0] tgt;
    int idx;
    rdy = !m_valid || out_ready;
    acc = valid && rdy && !flush;
    if (flush) m_valid = 0;
    else if (acc) begin
      resolve(alu_op, op1, op2, pc, imm, pred_target, pred_taken, tk, tgt, mis);
      m_valid    = 1;
      m_tag      = rob_tag;
      m_taken    = tk;
      m_target   = tgt;
      m_redirect = tk ? tgt : pc + 4;
      m_mis      = mis;
      m_result   = pc + 4;
      if (alu_op != JAL && alu_op != JALR) begin
        idx = m_idx(pc);
        if (tk) m_bht[idx] = (m_bht[idx] == 3) ? 3 : m_bht[idx] + 1;
        else    m_bht[idx] = (m_bht[idx] == 0) ? 0 : m_bht[idx] - 1;
        m_hist = (m_hist * 2 + (tk ? 1 : 0)) % ENTRIES;
      end
    end else if (out_ready) m_valid = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic set_instr(input logic [3:0] op, input logic [DW-1:0] a, b, p, im,
                           input logic [RW-1:0] tag, input logic ptk, input logic [DW-1:0] ptgt);
    valid = 1; alu_op = op; op1 = a; op2 = b; pc = p; imm = im;
    rob_tag = tag; pred_taken = ptk; pred_target = ptgt;
  endtask

  task automatic apply_reset();
    rst_n = 0; valid = 0; flush = 0;
    model_reset();
    #2;
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_reset();
    rst_n = 0; valid = 0; flush = 0; out_ready = 1; fetch_pc = '0;
    op1 = '0; op2 = '0; pc = '0; imm = '0; alu_op = '0; rob_tag = '0;
    pred_taken = 0; pred_target = '0;
    model_reset();
    #7;
    tests_run++;
    if ({res_valid, res_tag, taken, target_addr, redirect_pc, mispredict, result} !== '0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got %h expected 0",
               {res_valid, res_tag, taken, target_addr, redirect_pc, mispredict, result});
    end
    tests_run++;
    if (fetch_pred !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_fetch_pred: got %b expected 0", fetch_pred);
    end
    tests_run++;
    if (ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_ready: got %b expected 1", ready);
    end
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_beq();
    out_ready = 1;
    set_instr(BEQ, 32'd5, 32'd5, 32'h100, 32'h20, 4'h3, 1'b0, 32'h0);
    tick();
    valid = 0;
    tests_run++;
    if ({res_valid, taken, mispredict, redirect_pc, result, res_tag} !==
        {1'b1, 1'b1, 1'b1, 32'h120, 32'h104, 4'h3}) begin
      tests_failed++;
      $display("FAIL beq: got v%b t%b m%b rd=%h res=%h tag=%h expected v1 t1 m1 rd=120 res=104 tag=3",
               res_valid, taken, mispredict, redirect_pc, result, res_tag);
    end
  endtask

  task automatic test_blt_bltu();
    out_ready = 1;
    set_instr(BLT, 32'hFFFF_FFFF, 32'd1, 32'h200, 32'h10, 4'h4, 1'b1, 32'h210);
    tick();
    tests_run++;
    if ({res_valid, taken, mispredict, redirect_pc} !== {1'b1, 1'b1, 1'b0, 32'h210}) begin
      tests_failed++;
      $display("FAIL blt: got v%b t%b m%b rd=%h expected v1 t1 m0 rd=210",
               res_valid, taken, mispredict, redirect_pc);
    end
    set_instr(BLTU, 32'hFFFF_FFFF, 32'd1, 32'h200, 32'h10, 4'h5, 1'b1, 32'h210);
    tick();
    valid = 0;
    tests_run++;
    if ({res_valid, taken, mispredict, redirect_pc, res_tag} !== {1'b1, 1'b0, 1'b1, 32'h204, 4'h5}) begin
      tests_failed++;
      $display("FAIL bltu: got v%b t%b m%b rd=%h tag=%h expected v1 t0 m1 rd=204 tag=5",
               res_valid, taken, mispredict, redirect_pc, res_tag);
    end
  endtask

  task automatic test_jalr();
    out_ready = 1;
    set_instr(JALR, 32'h203, 32'h0, 32'h300, 32'h2, 4'h6, 1'b1, 32'h204);
    tick();
    tests_run++;
    if ({taken, target_addr, mispredict, redirect_pc, result} !==
        {1'b1, 32'h204, 1'b0, 32'h204, 32'h304}) begin
      tests_failed++;
      $display("FAIL jalr_hit: got t%b tgt=%h m%b rd=%h res=%h expected t1 tgt=204 m0 rd=204 res=304",
               taken, target_addr, mispredict, redirect_pc, result);
    end
    set_instr(JALR, 32'h203, 32'h0, 32'h300, 32'h2, 4'h7, 1'b1, 32'h208);
    tick();
    valid = 0;
    tests_run++;
    if ({taken, target_addr, mispredict} !== {1'b1, 32'h204, 1'b1}) begin
      tests_failed++;
      $display("FAIL jalr_wrong_target: got t%b tgt=%h m%b expected t1 tgt=204 m1",
               taken, target_addr, mispredict);
    end
  endtask

  task automatic test_bht_train();
    logic exp_seq [8];
    logic exp;
    exp_seq = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    apply_reset();
    out_ready = 1;
    fetch_pc  = 32'h40;
    #1;
    tests_run++;
    if (fetch_pred !== exp_seq[0]) begin
      tests_failed++;
      $display("FAIL bht_initial: got %b expected %b", fetch_pred, exp_seq[0]);
    end
    for (int k = 1; k < 8; k++) begin
      if (k <= 3) set_instr(BEQ, 32'd7, 32'd7, 32'h40, 32'h8, 4'h1, 1'b0, 32'h0);
      else        set_instr(BNE, 32'd7, 32'd7, 32'h40, 32'h8, 4'h1, 1'b0, 32'h0);
`ifdef BRANCH_UNIT_BP_GSHARE_EN
      exp = m_pred(fetch_pc);
`else
      exp = exp_seq[k-1];
`endif
      #1;
      tests_run++;
      if (fetch_pred !== exp) begin
        tests_failed++;
        $display("FAIL bht_pre_update step%0d: got %b expected %b", k, fetch_pred, exp);
      end
      tick();
`ifdef BRANCH_UNIT_BP_GSHARE_EN
      exp = m_pred(fetch_pc);
`else
      exp = exp_seq[k];
`endif
      tests_run++;
      if (fetch_pred !== exp) begin
        tests_failed++;
        $display("FAIL bht_train step%0d: got %b expected %b", k, fetch_pred, exp);
      end
    end
    valid = 0;
  endtask

  task automatic test_backpressure();
    out_ready = 1;
    set_instr(JAL, 32'h0, 32'h0, 32'h500, 32'h40, 4'h5, 1'b0, 32'h0);
    tick();
    out_ready = 0;
    set_instr(BEQ, 32'd1, 32'd2, 32'h600, 32'h80, 4'h6, 1'b0, 32'h0);
    for (int c = 0; c < 5; c++) begin
      #1;
      tests_run++;
      if (ready !== 1'b0) begin
        tests_failed++;
        $display("FAIL stall_ready cycle%0d: got %b expected 0", c, ready);
      end
      tick();
      tests_run++;
      if ({res_valid, res_tag, taken, target_addr, redirect_pc, mispredict, result} !==
          {1'b1, 4'h5, 1'b1, 32'h540, 32'h540, 1'b1, 32'h504}) begin
        tests_failed++;
        $display("FAIL stall_hold cycle%0d: got v%b tag=%h t%b tgt=%h rd=%h m%b res=%h expected v1 tag=5 t1 tgt=540 rd=540 m1 res=504",
                 c, res_valid, res_tag, taken, target_addr, redirect_pc, mispredict, result);
      end
    end
    out_ready = 1;
    #1;
    tests_run++;
    if (ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL release_ready: got %b expected 1", ready);
    end
    tick();
    valid = 0;
    tests_run++;
    if ({res_valid, res_tag, taken, redirect_pc} !== {1'b1, 4'h6, 1'b0, 32'h604}) begin
      tests_failed++;
      $display("FAIL release_accept: got v%b tag=%h t%b rd=%h expected v1 tag=6 t0 rd=604",
               res_valid, res_tag, taken, redirect_pc);
    end
  endtask

  task automatic test_flush();
    logic exp_pred;
    out_ready = 1;
    set_instr(BEQ, 32'd3, 32'd3, 32'h80, 32'h4, 4'h2, 1'b1, 32'h84);
    tick();
    out_ready = 0;
    flush     = 1;
    fetch_pc  = 32'h40;
    set_instr(BEQ, 32'd9, 32'd9, 32'h40, 32'h4, 4'h3, 1'b0, 32'h0);
    exp_pred = m_pred(32'h40);
    tick();
    flush = 0;
    valid = 0;
    tests_run++;
    if (res_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL flush_valid: got %b expected 0", res_valid);
    end
    tests_run++;
    if (fetch_pred !== exp_pred) begin
      tests_failed++;
      $display("FAIL flush_bht: got %b expected %b", fetch_pred, exp_pred);
    end
    out_ready = 1;
  endtask

  task automatic test_random();
    logic tk, mis;
    logic [DW-1:0] tgt;
    for (int n = 0; n < 400; n++) begin
      valid     = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 15) == 0);
      alu_op    = 4'($urandom_range(0, 15));
      op1       = $urandom;
      case ($urandom_range(0, 2))
        0:       op2 = op1;
        1:       op2 = $urandom;
        default: op2 = op1 + 32'($urandom_range(0, 2)) - 32'd1;
      endcase
      pc         = ($urandom_range(0, 7) == 0) ? $urandom : ($urandom & 32'h3FF);
      imm        = ($urandom_range(0, 1) == 0) ? $urandom : 32'($signed(12'($urandom)));
      rob_tag    = 4'($urandom);
      pred_taken = $urandom_range(0, 1) == 1;
      resolve(alu_op, op1, op2, pc, imm, 32'h0, 1'b0, tk, tgt, mis);
      pred_target = ($urandom_range(0, 2) != 0) ? tgt : $urandom;
      fetch_pc    = ($urandom_range(0, 1) == 1) ? pc : ($urandom & 32'hFF);
      #1;
      tests_run++;
      if ({ready, fetch_pred} !== {(!m_valid || out_ready), m_pred(fetch_pc)}) begin
        tests_failed++;
        $display("FAIL rand_comb n%0d: got ready=%b pred=%b expected ready=%b pred=%b",
                 n, ready, fetch_pred, (!m_valid || out_ready), m_pred(fetch_pc));
      end
      tick();
      tests_run++;
      if ({res_valid, res_tag, taken, target_addr, redirect_pc, mispredict, result} !==
          {m_valid, m_tag, m_taken, m_target, m_redirect, m_mis, m_result}) begin
        tests_failed++;
        $display("FAIL rand_out n%0d: got %h expected %h", n,
                 {res_valid, res_tag, taken, target_addr, redirect_pc, mispredict, result},
                 {m_valid, m_tag, m_taken, m_target, m_redirect, m_mis, m_result});
      end
    end
    valid = 0; flush = 0; out_ready = 1;
  endtask

  task automatic test_reset_mid();
    logic [ENTRIES-1:0] preds;
    out_ready = 0;
    set_instr(BEQ, 32'd4, 32'd4, 32'h40, 32'h10, 4'h9, 1'b0, 32'h0);
    tick();
    #2;
    rst_n = 0;
    model_reset();
    #1;
    tests_run++;
    if ({res_valid, res_tag, taken, target_addr, redirect_pc, mispredict, result} !== '0) begin
      tests_failed++;
      $display("FAIL midreset_outputs: got %h expected 0",
               {res_valid, res_tag, taken, target_addr, redirect_pc, mispredict, result});
    end
    for (int e = 0; e < ENTRIES; e++) begin
      fetch_pc = 32'(e) << 2;
      #1;
      preds[e] = fetch_pred;
    end
    tests_run++;
    if (preds !== '0) begin
      tests_failed++;
      $display("FAIL midreset_bht: got %h expected 0", preds);
    end
    valid = 0;
    @(negedge clk);
    rst_n = 1;
    out_ready = 1;
    set_instr(BNE, 32'd1, 32'd2, 32'h40, 32'h10, 4'hA, 1'b1, 32'h50);
    fetch_pc = 32'h40;
    tick();
    valid = 0;
    tests_run++;
    if ({res_valid, res_tag, taken, mispredict, redirect_pc, fetch_pred} !==
        {m_valid, m_tag, m_taken, m_mis, m_redirect, m_pred(32'h40)}) begin
      tests_failed++;
      $display("FAIL post_reset_op: got v%b tag=%h t%b m%b rd=%h p%b expected v%b tag=%h t%b m%b rd=%h p%b",
               res_valid, res_tag, taken, mispredict, redirect_pc, fetch_pred,
               m_valid, m_tag, m_taken, m_mis, m_redirect, m_pred(32'h40));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_beq();
    test_blt_bltu();
    test_jalr();
    test_bht_train();
    test_backpressure();
    test_flush();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
`default_nettype wire
